// File: rtl/ddr_ctrl_pkg.sv
// Shared definitions for the controller-side HDR-DDR frame counter:
// FSM states, word/CRC bit-cell counts and preamble bit positions.
package ddr_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_CRC   = 2'd2,
      ST_DONE  = 2'd3
   } ctfc_state_e;

   localparam int DDR_WORD_BITS = 20;
   localparam int DDR_CRC_BITS  = 11;
   localparam int DDR_IDX_W     = 5;

   // Preamble occupies the first two bit-cells of every word.
   localparam int DDR_PRE_IDX0  = 0;
   localparam int DDR_PRE_IDX1  = 1;

endpackage

// File: rtl/ddr_bit_pos_cnt.sv
// Modulo-N bit-position counter: advances on each tick, wraps to the first
// preamble cell and raises a combinational wrap pulse on the final cell.
module ddr_bit_pos_cnt
   import ddr_ctrl_pkg::*;
#(
   parameter int N = DDR_WORD_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic                 i_tick,
   output logic [DDR_IDX_W-1:0] o_idx,
   output logic                 o_wrap
);

   logic [DDR_IDX_W-1:0] r_idx;
   logic                 w_last;

   assign w_last = (r_idx == DDR_IDX_W'(N - 1));
   assign o_wrap = i_tick && w_last;
   assign o_idx  = r_idx;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_idx <= DDR_IDX_W'(DDR_PRE_IDX0);
      end else if (i_tick) begin
         r_idx <= w_last ? DDR_IDX_W'(DDR_PRE_IDX0) : r_idx + DDR_IDX_W'(1);
      end
   end

endmodule

// File: rtl/ddr_ctrl_frame_counter.sv
// Controller HDR-DDR frame counter: tracks bit position and counts data words
// down from the programmed length. Optional CRC word: define DDR_CTFC_CRC_EN.
module ddr_ctrl_frame_counter
   import ddr_ctrl_pkg::*;
#(
   parameter int WORD_BITS = DDR_WORD_BITS,
   parameter int LEN_W     = 16
) (
   input  logic             i_ctfc_clk,
   input  logic             i_ctfc_rst,
   input  logic             i_ctfc_en,
   input  logic             i_regf_RNW,
   input  logic [LEN_W-1:0] i_regf_DATA_LEN,
   input  logic             i_bitcnt_toggle,
   input  logic             i_ctfc_tgt_end,
   output logic [4:0]       o_ctfc_bit_idx,
   output logic             o_ctfc_word_done,
   output logic             o_ctfc_last_frame,
   output logic [LEN_W-1:0] o_ctfc_words_cnt,
   output logic             o_ctfc_done,
   output logic             o_ctfc_early_term
);

   ctfc_state_e          r_state;
   logic [LEN_W-1:0]     r_remaining;
   logic [LEN_W-1:0]     r_words_cnt;
   logic                 r_rnw;
   logic                 r_last_frame;
   logic                 r_word_done;
   logic                 r_done;
   logic                 r_early_term;

   logic [DDR_IDX_W-1:0] w_data_idx;
   logic                 w_data_wrap;
   logic                 w_data_tick;
   logic                 w_data_clr;
   logic                 w_early;

   // Toggles only count while a transfer is live; en low discards them.
   assign w_data_tick = i_bitcnt_toggle && i_ctfc_en && (r_state == ST_COUNT);
   assign w_early     = w_data_tick && r_rnw && i_ctfc_tgt_end &&
                        (w_data_idx == DDR_IDX_W'(DDR_PRE_IDX1));
   assign w_data_clr  = (r_state != ST_COUNT) || !i_ctfc_en || w_early;

   ddr_bit_pos_cnt #(.N(WORD_BITS)) u_data_pos (
      .i_clk  (i_ctfc_clk),
      .i_rst  (i_ctfc_rst),
      .i_clr  (w_data_clr),
      .i_tick (w_data_tick),
      .o_idx  (w_data_idx),
      .o_wrap (w_data_wrap)
   );

`ifdef DDR_CTFC_CRC_EN
   logic [DDR_IDX_W-1:0] w_crc_idx;
   logic                 w_crc_wrap;
   logic                 w_crc_tick;
   logic                 w_crc_clr;

   assign w_crc_tick = i_bitcnt_toggle && i_ctfc_en && (r_state == ST_CRC);
   assign w_crc_clr  = (r_state != ST_CRC) || !i_ctfc_en;

   ddr_bit_pos_cnt #(.N(DDR_CRC_BITS)) u_crc_pos (
      .i_clk  (i_ctfc_clk),
      .i_rst  (i_ctfc_rst),
      .i_clr  (w_crc_clr),
      .i_tick (w_crc_tick),
      .o_idx  (w_crc_idx),
      .o_wrap (w_crc_wrap)
   );

   localparam ctfc_state_e DATA_END_STATE = ST_CRC;
   localparam logic        DATA_END_DONE  = 1'b0;
`else
   localparam ctfc_state_e DATA_END_STATE = ST_DONE;
   localparam logic        DATA_END_DONE  = 1'b1;
`endif

   always_ff @(posedge i_ctfc_clk) begin
      if (i_ctfc_rst) begin
         r_state      <= ST_IDLE;
         r_remaining  <= '0;
         r_words_cnt  <= '0;
         r_rnw        <= 1'b0;
         r_last_frame <= 1'b0;
         r_word_done  <= 1'b0;
         r_done       <= 1'b0;
         r_early_term <= 1'b0;
      end else begin
         r_word_done <= 1'b0;
         r_done      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_ctfc_en) begin
                  r_remaining  <= i_regf_DATA_LEN;
                  r_rnw        <= i_regf_RNW;
                  r_words_cnt  <= '0;
                  r_early_term <= 1'b0;
                  if (i_regf_DATA_LEN == '0) begin
                     r_state      <= ST_DONE;
                     r_done       <= 1'b1;
                     r_last_frame <= 1'b0;
                  end else begin
                     r_state      <= ST_COUNT;
                     r_last_frame <= (i_regf_DATA_LEN == LEN_W'(1));
                  end
               end
            end
            ST_COUNT: begin
               if (!i_ctfc_en) begin
                  r_state      <= ST_IDLE;
                  r_remaining  <= '0;
                  r_last_frame <= 1'b0;
               end else if (w_early) begin
                  r_state      <= DATA_END_STATE;
                  r_done       <= DATA_END_DONE;
                  r_early_term <= 1'b1;
                  r_last_frame <= 1'b0;
               end else if (w_data_wrap) begin
                  r_word_done <= 1'b1;
                  r_remaining <= (r_remaining != '0) ? r_remaining - LEN_W'(1) : '0;
                  if (r_words_cnt != '1) begin
                     r_words_cnt <= r_words_cnt + LEN_W'(1);
                  end
                  if (r_remaining <= LEN_W'(1)) begin
                     r_state      <= DATA_END_STATE;
                     r_done       <= DATA_END_DONE;
                     r_last_frame <= 1'b0;
                  end else begin
                     r_last_frame <= (r_remaining == LEN_W'(2));
                  end
               end
            end
`ifdef DDR_CTFC_CRC_EN
            ST_CRC: begin
               if (!i_ctfc_en) begin
                  r_state     <= ST_IDLE;
                  r_remaining <= '0;
               end else if (w_crc_wrap) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
`endif
            ST_DONE: begin
               if (!i_ctfc_en) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ctfc_bit_idx    = w_data_idx;
   assign o_ctfc_word_done  = r_word_done;
   assign o_ctfc_last_frame = r_last_frame;
   assign o_ctfc_words_cnt  = r_words_cnt;
   assign o_ctfc_done       = r_done;
   assign o_ctfc_early_term = r_early_term;

endmodule

// File: tb/tb_ddr_ctrl_frame_counter.sv
// Self-checking bench for ddr_ctrl_frame_counter: directed scenarios plus
// randomized transfers against a tick-count reference model.
module tb_ddr_ctrl_frame_counter;

   localparam int WB       = 20;
   localparam int CRC_B    = 11;
   localparam int P_IDLE   = 0;
   localparam int P_DATA   = 1;
   localparam int P_CRC    = 2;
   localparam int P_DONE   = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        rnw;
   logic [15:0] len;
   logic        tog;
   logic        tgt;

   logic [4:0]  o_bit_idx;
   logic        o_word_done;
   logic        o_last_frame;
   logic [15:0] o_words_cnt;
   logic        o_done;
   logic        o_early_term;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: everything derives from ticks counted since load.
   int m_phase = P_IDLE;
   int m_ticks = 0;
   int m_len   = 0;
   int m_words = 0;
   int m_crc   = 0;
   bit m_rnw   = 1'b0;
   bit m_early = 1'b0;
   bit e_wd    = 1'b0;
   bit e_done  = 1'b0;

   int n_wd   = 0;
   int n_done = 0;

   always #5 clk = ~clk;

   ddr_ctrl_frame_counter dut (
      .i_ctfc_clk        (clk),
      .i_ctfc_rst        (rst),
      .i_ctfc_en         (en),
      .i_regf_RNW        (rnw),
      .i_regf_DATA_LEN   (len),
      .i_bitcnt_toggle   (tog),
      .i_ctfc_tgt_end    (tgt),
      .o_ctfc_bit_idx    (o_bit_idx),
      .o_ctfc_word_done  (o_word_done),
      .o_ctfc_last_frame (o_last_frame),
      .o_ctfc_words_cnt  (o_words_cnt),
      .o_ctfc_done       (o_done),
      .o_ctfc_early_term (o_early_term)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic end_data();
`ifdef DDR_CTFC_CRC_EN
      m_phase = P_CRC;
      m_crc   = 0;
`else
      m_phase = P_DONE;
      e_done  = 1'b1;
`endif
   endtask

   task automatic model_step();
      e_wd   = 1'b0;
      e_done = 1'b0;
      if (rst) begin
         m_phase = P_IDLE;
         m_ticks = 0;
         m_words = 0;
         m_early = 1'b0;
         m_crc   = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (en) begin
               m_len   = int'(len);
               m_rnw   = rnw;
               m_words = 0;
               m_early = 1'b0;
               m_ticks = 0;
               if (m_len == 0) begin
                  m_phase = P_DONE;
                  e_done  = 1'b1;
               end else begin
                  m_phase = P_DATA;
               end
            end
            P_DATA: begin
               if (!en) begin
                  m_phase = P_IDLE;
                  m_ticks = 0;
               end else if (tog) begin
                  if (m_rnw && tgt && (m_ticks % WB == 1)) begin
                     m_early = 1'b1;
                     end_data();
                  end else begin
                     m_ticks++;
                     if (m_ticks % WB == 0) begin
                        e_wd = 1'b1;
                        if (m_words < 65535) m_words++;
                     end
                     if (m_ticks == WB * m_len) end_data();
                  end
               end
            end
            P_CRC: begin
               if (!en) begin
                  m_phase = P_IDLE;
               end else if (tog) begin
                  m_crc++;
                  if (m_crc == CRC_B) begin
                     m_phase = P_DONE;
                     e_done  = 1'b1;
                  end
               end
            end
            default: if (!en) m_phase = P_IDLE;
         endcase
      end
   endtask

   task automatic compare();
      int exp_idx;
      bit exp_last;
      exp_idx  = (m_phase == P_DATA) ? (m_ticks % WB) : 0;
      exp_last = (m_phase == P_DATA) && ((m_len - m_ticks / WB) == 1);
      check("bit_idx",    32'(o_bit_idx),    32'(exp_idx));
      check("word_done",  32'(o_word_done),  32'(e_wd));
      check("last_frame", 32'(o_last_frame), 32'(exp_last));
      check("words_cnt",  32'(o_words_cnt),  32'(m_words));
      check("done",       32'(o_done),       32'(e_done));
      check("early_term", 32'(o_early_term), 32'(m_early));
   endtask

   task automatic step(input logic t_en, input logic t_tog, input logic t_tgt);
      en  = t_en;
      tog = t_tog;
      tgt = t_tgt;
      @(posedge clk);
      #1;
      model_step();
      compare();
      if (o_word_done) n_wd++;
      if (o_done) n_done++;
   endtask

   initial begin
      int wd_at[$];
      int k;
      int done_k;

      rst = 1'b1; en = 1'b0; rnw = 1'b0; len = '0; tog = 1'b0; tgt = 1'b0;
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0);

      // Write of 3 words with a toggle every cycle.
      rnw = 1'b0; len = 16'd3; n_done = 0;
      step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 70; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (o_word_done) wd_at.push_back(i);
      end
      check("wr3_wd_count", 32'(wd_at.size()), 32'd3);
      if (wd_at.size() == 3) begin
         check("wr3_first_wd", 32'(wd_at[0]), 32'd19);
         check("wr3_wd_gap1", 32'(wd_at[1] - wd_at[0]), 32'd20);
         check("wr3_wd_gap2", 32'(wd_at[2] - wd_at[1]), 32'd20);
      end
      check("wr3_done_count", 32'(n_done), 32'd1);
      check("wr3_words", 32'(o_words_cnt), 32'd3);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Zero-length transfer.
      len = 16'd0;
      step(1'b1, 1'b1, 1'b0);
      check("len0_done", 32'(o_done), 32'd1);
      step(1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // tgt_end at bit 1 of word 3: ignored on write, honoured on read.
      for (int r = 0; r < 2; r++) begin
         rnw = r[0]; len = 16'd5; n_done = 0;
         step(1'b1, 1'b0, 1'b0);
         for (int i = 0; i < 110; i++) step(1'b1, 1'b1, i == 41);
         check("tgt_words", 32'(o_words_cnt), (r == 1) ? 32'd2 : 32'd5);
         check("tgt_early", 32'(o_early_term), 32'(r));
         check("tgt_done_count", 32'(n_done), 32'd1);
         step(1'b0, 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end

      // Abort at bit 9 of word 2 of 4, with a toggle on the falling-en cycle.
      rnw = 1'b0; len = 16'd4; n_done = 0;
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 29; i++) step(1'b1, 1'b1, 1'b0);
      check("abort_pre_idx", 32'(o_bit_idx), 32'd9);
      step(1'b0, 1'b1, 1'b0);
      check("abort_idx", 32'(o_bit_idx), 32'd0);
      check("abort_words_hold", 32'(o_words_cnt), 32'd1);
      step(1'b0, 1'b0, 1'b0);
      check("abort_no_done", 32'(n_done), 32'd0);
      len = 16'd1;
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 45; i++) step(1'b1, 1'b1, 1'b0);
      check("reen_done_count", 32'(n_done), 32'd1);
      check("reen_early", 32'(o_early_term), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // Reset mid-word together with a toggle.
      len = 16'd3;
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 27; i++) step(1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      check("rst_idx",   32'(o_bit_idx),    32'd0);
      check("rst_words", 32'(o_words_cnt),  32'd0);
      check("rst_last",  32'(o_last_frame), 32'd0);
      rst = 1'b0;
      step(1'b0, 1'b0, 1'b0);

`ifdef DDR_CTFC_CRC_EN
      // One data word followed by the 11-cell CRC word.
      len = 16'd1; done_k = -1;
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (o_done) begin
            done_k = i;
            break;
         end
      end
      check("crc_done_ticks", 32'(done_k + 1), 32'd31);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
`endif

      // Randomized transfers with sparse toggles, tgt_end and occasional aborts.
      for (int t = 0; t < 25; t++) begin
         len = 16'($urandom_range(0, 4));
         rnw = 1'($urandom_range(0, 1));
         k   = $urandom_range(10, 130);
         step(1'b1, 1'b0, 1'b0);
         for (int i = 0; i < k; i++) begin
            step($urandom_range(0, 149) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 5) == 0);
         end
         step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         step(1'b0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
